// File: rtl/prio_dec_pkg.sv
// Shared types and helpers for the priority-index decoder block.
// The optional parity check is controlled by the PRIO_DEC_PARITY_EN macro (see prio_dec_ctrl).
package prio_dec_pkg;

    // Decoder FSM: IDLE waits for buffered work, DRIVE holds a one-hot word on the output.
    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam int DEF_IDX_W       = 2;
    localparam int DEF_HOLD_CYCLES = 2;

    // onehot() is written for the widest supported index; callers cast the result down to OUT_W.
    localparam int MAX_IDX_W = 8;
    localparam int MAX_OUT_W = 1 << MAX_IDX_W;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_OUT_W-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/prio_dec_fifo.sv
// Small synchronous FIFO buffering encoded indices ahead of the decoder FSM.
// DEPTH must be a power of two so the pointers wrap naturally.
module prio_dec_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             do_push, do_pop;

    assign full    = (occ_q == CNT_W'(DEPTH));
    assign empty   = (occ_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // Qualify requests against occupancy; a full FIFO refuses a push even if a pop happens the same cycle.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d    = occ_q;
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Pointer and occupancy state; reset empties the buffer immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage array carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/prio_dec_ctrl.sv
// Sequential one-hot decoder: buffers encoded indices and replays each as a
// registered one-hot word held for HOLD_CYCLES cycles (extended by dec_stall).
// Define PRIO_DEC_PARITY_EN to add even-parity checking on idx_in (idx_par / par_err).
module prio_dec_ctrl
    import prio_dec_pkg::*;
#(
    parameter int IDX_W       = DEF_IDX_W,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int FIFO_DEPTH  = 2,
    localparam int OUT_W      = 2 ** IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx_in,
    input  logic             idx_valid,
    output logic             idx_ready,
    input  logic             dec_stall,
    output logic [OUT_W-1:0] dec_out,
    output logic             dec_valid,
    output logic             busy,
    output logic [7:0]       dec_count
`ifdef PRIO_DEC_PARITY_EN
    ,
    input  logic             idx_par,
    output logic             par_err
`endif
);
    localparam int          CNT_W       = 4;
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [OUT_W-1:0] dec_out_q, dec_out_d;
    logic             dec_valid_q, dec_valid_d;
    logic [7:0]       dec_count_q, dec_count_d;

    logic             fifo_push, fifo_pop;
    logic             fifo_full, fifo_empty;
    logic [IDX_W-1:0] fifo_rd_data;
    logic [OUT_W-1:0] next_word;
    logic             par_ok;

    prio_dec_fifo #(
        .W     (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (idx_in),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign idx_ready = !fifo_full;
    assign fifo_push = idx_valid && par_ok;
    assign next_word = OUT_W'(onehot(MAX_IDX_W'(fifo_rd_data)));
    assign dec_out   = dec_out_q;
    assign dec_valid = dec_valid_q;
    assign dec_count = dec_count_q;
    assign busy      = !fifo_empty || (state_q != IDLE);

`ifdef PRIO_DEC_PARITY_EN
    logic par_err_q, par_err_d;

    assign par_ok  = ((^idx_in) == idx_par);
    assign par_err = par_err_q;

    // Flag a handshaked entry whose parity bit disagrees; it was dropped instead of buffered.
    always_comb begin
        par_err_d = idx_valid && idx_ready && !par_ok;
    end

    // One-cycle parity error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`else
    assign par_ok = 1'b1;
`endif

    // Decoder FSM: load words from the FIFO, count down the hold, chain words without idle gaps.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        dec_out_d   = dec_out_q;
        dec_valid_d = dec_valid_q;
        dec_count_d = dec_count_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    dec_out_d   = next_word;
                    dec_valid_d = 1'b1;
                    hold_cnt_d  = HOLD_RELOAD;
                    state_d     = DRIVE;
                end
            end
            DRIVE: begin
                if (!dec_stall) begin
                    if (hold_cnt_q != '0) begin
                        hold_cnt_d = hold_cnt_q - CNT_W'(1);
                    end else begin
                        dec_count_d = dec_count_q + 8'd1;
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            dec_out_d  = next_word;
                            hold_cnt_d = HOLD_RELOAD;
                        end else begin
                            dec_out_d   = '0;
                            dec_valid_d = 1'b0;
                            state_d     = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                dec_out_d   = '0;
                dec_valid_d = 1'b0;
            end
        endcase
    end

    // Control and output registers; reset abandons any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            dec_out_q   <= '0;
            dec_valid_q <= 1'b0;
            dec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            dec_out_q   <= dec_out_d;
            dec_valid_q <= dec_valid_d;
            dec_count_q <= dec_count_d;
        end
    end

endmodule
